// File: rtl/se_mon_pkg.sv
// ============================================================================
// Module      : se_mon_pkg
// Description : Shared types and defaults for the dual-SE leak monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package se_mon_pkg;

    localparam int SKEW_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_ONE_AHEAD = 3'd2,
        ST_TWO_AHEAD = 3'd3,
        ST_REPORT    = 3'd4
    } state_t;

    typedef struct packed {
        logic one;
        logic two;
    } arrival_t;

endpackage

`default_nettype wire

// File: rtl/se_arrival_detect.sv
// ============================================================================
// Module      : se_arrival_detect
// Description : Rising-edge detector so a valid held through a stall counts once.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module se_arrival_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_rise
);

    logic r_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= i_valid;
        end
    end

    assign o_rise = i_valid & ~r_valid_q;

endmodule

`default_nettype wire

// File: rtl/se_leak_monitor.sv
// ============================================================================
// Module      : se_leak_monitor
// Description : Measures completion skew between two SE instances per
//               transaction and flags timing leaks, result mismatches, timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module se_leak_monitor
    import se_mon_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int SKEW_W  = SKEW_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_fire,
    input  logic              io_validOne,
    input  logic [DATA_W-1:0] io_resultOne,
    input  logic              io_validTwo,
    input  logic [DATA_W-1:0] io_resultTwo,
    input  logic              io_out_ready,
    output logic              timingLeak,
    output logic              timingLeakDone,
    output logic              resultMismatch,
    output logic              timeout,
    output logic              bothValid,
    output logic [SKEW_W-1:0] skew,
    output logic [CNT_W-1:0]  leakCount,
    output logic              busy
);

    localparam logic [SKEW_W-1:0] c_TIMEOUT = SKEW_W'(TIMEOUT);

    state_t              r_state, w_next;
    arrival_t            w_arr;
    logic [DATA_W-1:0]   r_capt;
    logic [SKEW_W-1:0]   r_skew_cnt, w_skew_nxt, w_skew_inc;
    logic [SKEW_W-1:0]   r_skew_out;
    logic [CNT_W-1:0]    r_leak_cnt;
    logic                r_leak, r_mismatch, r_timeout;
    logic                w_capture, w_capt_two, w_cmp_en, w_timeout_hit;
    logic [DATA_W-1:0]   w_cmp_a, w_cmp_b;
    logic                w_done, w_busy;
    logic                w_unused_ready;

    // The sink ready only stalls the SEs; edge detection already absorbs stalls.
    assign w_unused_ready = io_out_ready;

    se_arrival_detect u_det_one (
        .clk     (clock),
        .rst     (reset),
        .i_valid (io_validOne),
        .o_rise  (w_arr.one)
    );

    se_arrival_detect u_det_two (
        .clk     (clock),
        .rst     (reset),
        .i_valid (io_validTwo),
        .o_rise  (w_arr.two)
    );

    // Held at TIMEOUT so a last-moment arrival cannot wrap the counter.
    assign w_skew_inc = (r_skew_cnt == c_TIMEOUT) ? r_skew_cnt : r_skew_cnt + SKEW_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_skew_nxt    = r_skew_cnt;
        w_capture     = 1'b0;
        w_capt_two    = 1'b0;
        w_cmp_en      = 1'b0;
        w_timeout_hit = 1'b0;
        w_cmp_a       = io_resultOne;
        w_cmp_b       = io_resultTwo;
        case (r_state)
            ST_IDLE: begin
                if (io_in_fire) begin
                    w_next     = ST_ARMED;
                    w_skew_nxt = '0;
                end
            end
            ST_ARMED: begin
                w_skew_nxt = '0;
                if (w_arr.one && w_arr.two) begin
                    w_next   = ST_REPORT;
                    w_cmp_en = 1'b1;
                end else if (w_arr.one) begin
                    w_next    = ST_ONE_AHEAD;
                    w_capture = 1'b1;
                end else if (w_arr.two) begin
                    w_next     = ST_TWO_AHEAD;
                    w_capture  = 1'b1;
                    w_capt_two = 1'b1;
                end
            end
            ST_ONE_AHEAD: begin
                w_skew_nxt = w_skew_inc;
                w_cmp_a    = r_capt;
                if (w_arr.two) begin
                    w_next   = ST_REPORT;
                    w_cmp_en = 1'b1;
                end else if (r_skew_cnt == c_TIMEOUT) begin
                    w_next        = ST_REPORT;
                    w_timeout_hit = 1'b1;
                    w_skew_nxt    = r_skew_cnt;
                end
            end
            ST_TWO_AHEAD: begin
                w_skew_nxt = w_skew_inc;
                w_cmp_b    = r_capt;
                if (w_arr.one) begin
                    w_next   = ST_REPORT;
                    w_cmp_en = 1'b1;
                end else if (r_skew_cnt == c_TIMEOUT) begin
                    w_next        = ST_REPORT;
                    w_timeout_hit = 1'b1;
                    w_skew_nxt    = r_skew_cnt;
                end
            end
            ST_REPORT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_done = (r_state == ST_REPORT);
        w_busy = (r_state != ST_IDLE);
    end

    // Report results are latched on entry to REPORT so they line up with the pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_skew_cnt <= '0;
            r_capt     <= '0;
            r_skew_out <= '0;
            r_leak_cnt <= '0;
            r_leak     <= 1'b0;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_skew_cnt <= w_skew_nxt;
            if (w_capture) begin
                r_capt <= w_capt_two ? io_resultTwo : io_resultOne;
            end
            if (r_state != ST_REPORT && w_next == ST_REPORT) begin
                r_skew_out <= w_skew_nxt;
                if (w_skew_nxt != '0) begin
                    r_leak <= 1'b1;
                    if (r_leak_cnt != '1) begin
                        r_leak_cnt <= r_leak_cnt + CNT_W'(1);
                    end
                end
                if (w_cmp_en && (w_cmp_a != w_cmp_b)) begin
                    r_mismatch <= 1'b1;
                end
                if (w_timeout_hit) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign timingLeak     = r_leak;
    assign timingLeakDone = w_done;
    assign resultMismatch = r_mismatch;
    assign timeout        = r_timeout;
    assign bothValid      = io_validOne & io_validTwo;
    assign skew           = r_skew_out;
    assign leakCount      = r_leak_cnt;
    assign busy           = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_se_leak_monitor.sv
// ============================================================================
// Module      : tb_se_leak_monitor
// Description : Directed self-checking bench for se_leak_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_se_leak_monitor;

    localparam int DATA_W  = 128;
    localparam int SKEW_W  = 8;
    localparam int TIMEOUT = 255;
    localparam int CNT_W   = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_in_fire;
    logic              io_validOne;
    logic [DATA_W-1:0] io_resultOne;
    logic              io_validTwo;
    logic [DATA_W-1:0] io_resultTwo;
    logic              io_out_ready;
    logic              timingLeak;
    logic              timingLeakDone;
    logic              resultMismatch;
    logic              timeout;
    logic              bothValid;
    logic [SKEW_W-1:0] skew;
    logic [CNT_W-1:0]  leakCount;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_wait;

    se_leak_monitor #(
        .DATA_W  (DATA_W),
        .SKEW_W  (SKEW_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .io_in_fire     (io_in_fire),
        .io_validOne    (io_validOne),
        .io_resultOne   (io_resultOne),
        .io_validTwo    (io_validTwo),
        .io_resultTwo   (io_resultTwo),
        .io_out_ready   (io_out_ready),
        .timingLeak     (timingLeak),
        .timingLeakDone (timingLeakDone),
        .resultMismatch (resultMismatch),
        .timeout        (timeout),
        .bothValid      (bothValid),
        .skew           (skew),
        .leakCount      (leakCount),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_fire();
        io_in_fire = 1'b1;
        tick();
        io_in_fire = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (timingLeakDone !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        reset        = 1'b1;
        io_in_fire   = 1'b0;
        io_validOne  = 1'b0;
        io_validTwo  = 1'b0;
        io_resultOne = '0;
        io_resultTwo = '0;
        io_out_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_skew", skew, 0);
        check("rst_count", leakCount, 0);
        check("rst_flags", {timingLeak, timingLeakDone, resultMismatch, timeout}, 0);
        reset = 1'b0;
        tick();

        // Both arrive together with equal results
        do_fire();
        tick();
        io_validOne  = 1'b1;
        io_validTwo  = 1'b1;
        io_resultOne = 128'hABC;
        io_resultTwo = 128'hABC;
        #1;
        check("t1_both_valid", bothValid, 1);
        check("t1_no_early_done", timingLeakDone, 0);
        tick();
        io_validOne = 1'b0;
        io_validTwo = 1'b0;
        check("t1_done", timingLeakDone, 1);
        check("t1_skew", skew, 0);
        check("t1_leak", timingLeak, 0);
        check("t1_mismatch", resultMismatch, 0);
        tick();
        check("t1_pulse_end", timingLeakDone, 0);
        check("t1_idle", busy, 0);

        // Same-cycle arrival with differing results
        do_fire();
        io_validOne  = 1'b1;
        io_validTwo  = 1'b1;
        io_resultOne = 128'h1;
        io_resultTwo = 128'h2;
        tick();
        io_validOne = 1'b0;
        io_validTwo = 1'b0;
        check("t2_done", timingLeakDone, 1);
        check("t2_mismatch", resultMismatch, 1);
        check("t2_leak", timingLeak, 0);
        tick();

        // SE1 first, SE2 four cycles later; SE1 re-pulses and must be ignored
        do_fire();
        io_resultOne = 128'h55;
        io_resultTwo = 128'h55;
        io_validOne  = 1'b1;
        tick();
        io_validOne = 1'b0;
        tick();
        io_validOne = 1'b1;
        tick();
        io_validOne = 1'b0;
        tick();
        io_validTwo = 1'b1;
        tick();
        io_validTwo = 1'b0;
        check("t3_done", timingLeakDone, 1);
        check("t3_skew", skew, 4);
        check("t3_leak", timingLeak, 1);
        check("t3_count", leakCount, 1);
        tick();
        check("t3_idle", busy, 0);

        // Only SE2 arrives: timeout after TIMEOUT cycles of skew
        do_fire();
        io_validTwo = 1'b1;
        wait_done(400, n_wait);
        io_validTwo = 1'b0;
        check("t4_latency", n_wait, 257);
        check("t4_timeout", timeout, 1);
        check("t4_skew", skew, 255);
        check("t4_mismatch_kept", resultMismatch, 1);
        check("t4_count", leakCount, 2);
        tick();
        check("t4_idle", busy, 0);

        // SE1 valid held through a stall, SE2 single-cycle pulse three cycles later
        io_out_ready = 1'b0;
        do_fire();
        io_resultOne = 128'h7;
        io_resultTwo = 128'h7;
        io_validOne  = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        io_validTwo = 1'b1;
        tick();
        io_validTwo = 1'b0;
        check("t5_done", timingLeakDone, 1);
        check("t5_skew", skew, 3);
        check("t5_count", leakCount, 3);
        for (int i = 0; i < 6; i++) tick();
        io_validOne  = 1'b0;
        io_out_ready = 1'b1;
        check("t5_idle", busy, 0);
        tick();

        // Asynchronous reset while SE1 is ahead
        do_fire();
        io_validOne = 1'b1;
        tick();
        io_validOne = 1'b0;
        tick();
        tick();
        check("t6_ahead_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_skew", skew, 0);
        check("t6_rst_count", leakCount, 0);
        check("t6_rst_flags", {timingLeak, timingLeakDone, resultMismatch, timeout}, 0);
        tick();
        reset = 1'b0;
        tick();
        do_fire();
        io_resultOne = 128'h9;
        io_resultTwo = 128'h9;
        io_validOne  = 1'b1;
        io_validTwo  = 1'b1;
        tick();
        io_validOne = 1'b0;
        io_validTwo = 1'b0;
        check("t6_done", timingLeakDone, 1);
        check("t6_skew", skew, 0);
        check("t6_flags", {timingLeak, resultMismatch, timeout}, 0);
        tick();
        check("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
